// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: shared FSM type, default timing and lane helper for the SRAM bridge
package sram_bridge_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;
  localparam int WAIT_STATES_DEF = 1;
  // Byte at lane a of the two-bank row: a[1] picks the bank, a[0] the byte within it.
  function automatic logic [7:0] lane_byte(input logic [15:0] d0, input logic [15:0] d1,
                                           input logic [1:0] a);
    return a[1] ? (a[0] ? d1[15:8] : d1[7:0]) : (a[0] ? d0[15:8] : d0[7:0]);
  endfunction
endpackage

// File: rtl/sram_lane_dec.sv
// sram_lane_dec: maps access size, address low bits and split phase to byte enables and write steering
//   byte_i, addr_i, phase_i, write_i, wr_data_i -> en_o {b1 hi, b1 lo, b0 hi, b0 lo} (active-high),
//   drv_o {bank1, bank0} pin drive enables, split_o (word at addr[1:0]=3), wd_o steered write data
module sram_lane_dec (
  input  logic        byte_i,
  input  logic [1:0]  addr_i,
  input  logic        phase_i,
  input  logic        write_i,
  input  logic [15:0] wr_data_i,
  output logic [3:0]  en_o,
  output logic [1:0]  drv_o,
  output logic        split_o,
  output logic [15:0] wd_o
);
  logic [3:0] hot;
  always_comb begin
    hot = 4'b0001 << addr_i;
    split_o = !byte_i && addr_i == 2'd3;
    // A word covers the addressed lane and the next one; the split case takes one lane per phase.
    en_o = byte_i ? hot : split_o ? (phase_i ? 4'b0001 : 4'b1000) : hot | (hot << 1);
    drv_o = {2{write_i}} & {|en_o[3:2], |en_o[1:0]};
    // An odd address puts the low data byte in a high lane, so swap the halves.
    wd_o = byte_i ? {2{wr_data_i[7:0]}} : addr_i[0] ? {wr_data_i[7:0], wr_data_i[15:8]} : wr_data_i;
  end
endmodule

// File: rtl/sram_bridge.sv
// sram_bridge: turns 20-bit byte-addressed CPU requests into timed cycles on two 16-bit async SRAM banks
//   clk, boot (async active-high reset); CPU side: stb, we (1=read), byte_m, addr, wr_data, rd_data, ack
//   SRAM side: addr_ row, data0_/data1_ bank data, roe_/rwe_/rcs_ strobes, rble*_/rbhe*_ byte enables
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic        clk,
  input  logic        boot,
  input  logic        stb,
  input  logic        we,
  input  logic        byte_m,
  input  logic [19:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        ack,
  output logic [17:0] addr_,
  inout  wire  [15:0] data0_,
  inout  wire  [15:0] data1_,
  output logic        roe_,
  output logic        rwe_,
  output logic        rcs_,
  output logic        rble0_,
  output logic        rbhe0_,
  output logic        rble1_,
  output logic        rbhe1_
);
  localparam int CW = $clog2(WAIT_STATES + 2);
  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, byte_q;
  logic [19:0]   addr_q;
  logic [15:0]   wd_q, rd_data_q;
  logic [7:0]    lo_q;
  logic [3:0]    en;
  logic [1:0]    drv;
  logic          split, busy, last, final_acc;
  logic [15:0]   wd;
  sram_lane_dec u_dec (
    .byte_i    (byte_q),
    .addr_i    (addr_q[1:0]),
    .phase_i   (phase_q),
    .write_i   (!we_q),
    .wr_data_i (wd_q),
    .en_o      (en),
    .drv_o     (drv),
    .split_o   (split),
    .wd_o      (wd)
  );
  assign busy = state_q != IDLE;
  assign last = cnt_q == CW'(WAIT_STATES);
  assign final_acc = !split || phase_q;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (stb) begin
        state_d = SETUP;
        phase_d = 1'b0;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d = '0;
      end
      STROBE: if (last) state_d = HOLD;
        else cnt_d = cnt_q + CW'(1);
      HOLD: if (final_acc) state_d = IDLE;
        else begin
          state_d = SETUP;
          phase_d = 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk or posedge boot) begin
    if (boot) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      cnt_q <= '0;
      we_q <= 1'b1;
      byte_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      rd_data_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && stb) begin
        we_q <= we;
        byte_q <= byte_m;
        addr_q <= addr;
        wd_q <= wr_data;
      end
      // The first half of a split read parks its byte so rd_data only changes alongside ack.
      if (state_q == STROBE && last && we_q) begin
        if (final_acc)
          rd_data_q <= {byte_q ? 8'h00 : lane_byte(data0_, data1_, addr_q[1:0] + 2'd1),
                        split ? lo_q : lane_byte(data0_, data1_, addr_q[1:0])};
        else
          lo_q <= lane_byte(data0_, data1_, addr_q[1:0]);
      end
    end
  end
  assign rd_data = rd_data_q;
  assign ack = state_q == HOLD && final_acc;
  assign addr_ = busy ? addr_q[19:2] + 18'(phase_q) : '0;
  assign rcs_ = !busy;
  assign roe_ = !(state_q == STROBE && we_q);
  assign rwe_ = !(state_q == STROBE && !we_q);
  assign {rbhe1_, rble1_, rbhe0_, rble0_} = ~(en & {4{busy}});
  assign data0_ = (busy && drv[0]) ? wd : 16'hzzzz;
  assign data1_ = (busy && drv[1]) ? wd : 16'hzzzz;
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: drives sram_bridge against async SRAM banks and a flat byte-memory reference
module tb_sram_bridge;
  logic clk = 1'b0;
  logic boot = 1'b1;
  logic stb = 1'b0, we = 1'b1, byte_m = 1'b0;
  logic [19:0] addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic ack;
  logic [17:0] sa;
  wire [15:0] d0, d1;
  logic roe, rwe, rcs, ble0, bhe0, ble1, bhe1;
  logic stb3 = 1'b0, we3 = 1'b1, byte3 = 1'b0;
  logic [19:0] addr3 = '0;
  logic [15:0] wr3 = '0;
  logic [15:0] rd_data3;
  logic ack3;
  logic [17:0] sa3;
  wire [15:0] d30, d31;
  logic roe3, rwe3, rcs3, ble30, bhe30, ble31, bhe31;
  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];
  logic [7:0] ref_mem [0:1048575];
  int n_cmp = 0, n_bad = 0;
  int got_lat;
  logic tr_roe [0:31];
  logic tr_rwe [0:31];
  logic [3:0] tr_en [0:31];
  logic [17:0] tr_sa [0:31];
  logic [15:0] tr_d1 [0:31];

  always #5 clk = ~clk;

  sram_bridge #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .boot(boot), .stb(stb), .we(we), .byte_m(byte_m), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ack(ack), .addr_(sa), .data0_(d0), .data1_(d1),
    .roe_(roe), .rwe_(rwe), .rcs_(rcs), .rble0_(ble0), .rbhe0_(bhe0), .rble1_(ble1), .rbhe1_(bhe1)
  );
  sram_bridge #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .boot(boot), .stb(stb3), .we(we3), .byte_m(byte3), .addr(addr3), .wr_data(wr3),
    .rd_data(rd_data3), .ack(ack3), .addr_(sa3), .data0_(d30), .data1_(d31),
    .roe_(roe3), .rwe_(rwe3), .rcs_(rcs3), .rble0_(ble30), .rbhe0_(bhe30), .rble1_(ble31), .rbhe1_(bhe31)
  );

  assign d0 = (!rcs && !roe) ? mem0[sa] : 16'hzzzz;
  assign d1 = (!rcs && !roe) ? mem1[sa] : 16'hzzzz;
  assign d30 = (!rcs3 && !roe3) ? mem0[sa3] : 16'hzzzz;
  assign d31 = (!rcs3 && !roe3) ? mem1[sa3] : 16'hzzzz;
  pullup (d0);
  pullup (d1);

  always @(posedge clk) begin
    if (!rcs && !rwe) begin
      if (!ble0) mem0[sa][7:0] <= d0[7:0];
      if (!bhe0) mem0[sa][15:8] <= d0[15:8];
      if (!ble1) mem1[sa][7:0] <= d1[7:0];
      if (!bhe1) mem1[sa][15:8] <= d1[15:8];
    end
  end

  function automatic logic [7:0] sram_byte(input logic [19:0] a);
    logic [15:0] w;
    w = a[1] ? mem1[a[19:2]] : mem0[a[19:2]];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic bit released(input logic [15:0] v);
    return v === 16'hzzzz || v === 16'hffff;
  endfunction

  task automatic op(input logic w, input logic b, input logic [19:0] a, input logic [15:0] wd,
                    input bit hold);
    for (int n = 0; n < 32; n++) begin
      tr_roe[n] = 1'b1;
      tr_rwe[n] = 1'b1;
      tr_en[n] = 4'hf;
      tr_sa[n] = '1;
      tr_d1[n] = '0;
    end
    @(negedge clk);
    we = w;
    byte_m = b;
    addr = a;
    wr_data = wd;
    stb = 1'b1;
    got_lat = -1;
    for (int n = 1; n <= 20 && got_lat < 0; n++) begin
      @(negedge clk);
      tr_roe[n] = roe;
      tr_rwe[n] = rwe;
      tr_en[n] = {bhe1, ble1, bhe0, ble0};
      tr_sa[n] = sa;
      tr_d1[n] = d1;
      if (n == 1) begin
        we = 1'($urandom);
        byte_m = 1'($urandom);
        addr = 20'($urandom);
        wr_data = 16'($urandom);
      end
      if (ack) begin
        got_lat = n;
        if (!hold) stb = 1'b0;
      end
    end
    if (got_lat < 0) stb = 1'b0;
  endtask

  task automatic test_reset();
    boot = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack, rd_data, sa} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_regs: ack=%b rd_data=%h addr_=%h, want 0/0000/00000", ack, rd_data, sa);
    end
    n_cmp++;
    if ({roe, rwe, rcs, ble0, bhe0, ble1, bhe1} !== 7'h7f) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 1111111", {roe, rwe, rcs, ble0, bhe0, ble1, bhe1});
    end
    n_cmp++;
    if (!released(d0) || !released(d1)) begin
      n_bad++;
      $display("FAIL reset_bus: d0=%h d1=%h, want released", d0, d1);
    end
    @(negedge clk);
    boot = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || rcs !== 1'b1 || ack3 !== 1'b0 || rcs3 !== 1'b1 || rd_data3 !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_idle: ack=%b rcs_=%b ack3=%b rcs3_=%b rd3=%h, want 0 1 0 1 0000",
               ack, rcs, ack3, rcs3, rd_data3);
    end
  endtask

  task automatic test_word_read();
    logic [15:0] exp;
    exp = {ref_mem[20'h11], ref_mem[20'h10]};
    op(1'b1, 1'b0, 20'h00010, 16'h0000, 1'b0);
    n_cmp++;
    if (got_lat != 4) begin n_bad++; $display("FAIL t1_latency: got %0d want 4", got_lat); end
    n_cmp++;
    if (rd_data !== exp) begin n_bad++; $display("FAIL t1_rd_data: got %h want %h", rd_data, exp); end
    n_cmp++;
    if ({tr_roe[4], tr_roe[3], tr_roe[2], tr_roe[1]} !== 4'b1001) begin
      n_bad++;
      $display("FAIL t1_roe: got %b want 1001", {tr_roe[4], tr_roe[3], tr_roe[2], tr_roe[1]});
    end
    n_cmp++;
    if (tr_en[2] !== 4'b1100 || tr_en[3] !== 4'b1100) begin
      n_bad++;
      $display("FAIL t1_enables: got %b/%b want 1100", tr_en[2], tr_en[3]);
    end
    n_cmp++;
    if (tr_sa[2] !== 18'h4) begin n_bad++; $display("FAIL t1_row: got %h want 00004", tr_sa[2]); end
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0) begin n_bad++; $display("FAIL t1_single_ack: got %b want 0", ack); end
  endtask

  task automatic test_byte_write();
    logic [15:0] prev;
    bit ok;
    prev = rd_data;
    ref_mem[20'h7] = 8'hAB;
    op(1'b0, 1'b1, 20'h00007, 16'h12AB, 1'b0);
    n_cmp++;
    if (got_lat != 4) begin n_bad++; $display("FAIL t2_latency: got %0d want 4", got_lat); end
    n_cmp++;
    if ({tr_rwe[4], tr_rwe[3], tr_rwe[2], tr_rwe[1]} !== 4'b1001) begin
      n_bad++;
      $display("FAIL t2_rwe: got %b want 1001", {tr_rwe[4], tr_rwe[3], tr_rwe[2], tr_rwe[1]});
    end
    n_cmp++;
    if (tr_en[2] !== 4'b0111) begin n_bad++; $display("FAIL t2_enables: got %b want 0111", tr_en[2]); end
    n_cmp++;
    if (tr_d1[2][15:8] !== 8'hAB) begin n_bad++; $display("FAIL t2_bus: got %h want AB", tr_d1[2][15:8]); end
    n_cmp++;
    if (rd_data !== prev) begin n_bad++; $display("FAIL t2_rd_hold: got %h want %h", rd_data, prev); end
    ok = 1'b1;
    for (int k = 0; k < 16; k++) if (sram_byte(20'(k)) !== ref_mem[k]) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL t2_memory: byte7=%h want AB, or a neighbour changed", sram_byte(20'h7));
    end
  endtask

  task automatic test_split_read();
    logic [15:0] exp;
    logic [7:0] roe_seq;
    exp = {ref_mem[20'h4], ref_mem[20'h3]};
    op(1'b1, 1'b0, 20'h00003, 16'h0000, 1'b0);
    n_cmp++;
    if (got_lat != 8) begin n_bad++; $display("FAIL t3_latency: got %0d want 8", got_lat); end
    n_cmp++;
    if (rd_data !== exp) begin n_bad++; $display("FAIL t3_rd_data: got %h want %h", rd_data, exp); end
    n_cmp++;
    if (tr_sa[2] !== 18'h0 || tr_sa[6] !== 18'h1) begin
      n_bad++;
      $display("FAIL t3_rows: got %h/%h want 00000/00001", tr_sa[2], tr_sa[6]);
    end
    for (int n = 1; n <= 8; n++) roe_seq[n-1] = tr_roe[n];
    n_cmp++;
    if (roe_seq !== 8'h99) begin n_bad++; $display("FAIL t3_roe: got %b want 10011001", roe_seq); end
    n_cmp++;
    if (tr_en[2] !== 4'b0111 || tr_en[6] !== 4'b1110) begin
      n_bad++;
      $display("FAIL t3_enables: got %b/%b want 0111/1110", tr_en[2], tr_en[6]);
    end
  endtask

  task automatic test_wrap_write();
    bit ok;
    logic [19:0] a;
    ref_mem[20'hFFFFF] = 8'hEF;
    ref_mem[20'h00000] = 8'hBE;
    op(1'b0, 1'b0, 20'hFFFFF, 16'hBEEF, 1'b0);
    n_cmp++;
    if (got_lat != 8) begin n_bad++; $display("FAIL t4_latency: got %0d want 8", got_lat); end
    n_cmp++;
    if (tr_sa[2] !== 18'h3FFFF || tr_sa[6] !== 18'h0) begin
      n_bad++;
      $display("FAIL t4_rows: got %h/%h want 3FFFF/00000", tr_sa[2], tr_sa[6]);
    end
    n_cmp++;
    if (tr_en[2] !== 4'b0111 || tr_en[6] !== 4'b1110) begin
      n_bad++;
      $display("FAIL t4_enables: got %b/%b want 0111/1110", tr_en[2], tr_en[6]);
    end
    ok = 1'b1;
    for (int k = -8; k < 8; k++) begin
      a = 20'(k);
      if (sram_byte(a) !== ref_mem[a]) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL t4_memory: top=%h want EF, bottom=%h want BE", sram_byte(20'hFFFFF), sram_byte(20'h0));
    end
  endtask

  task automatic test_boot_abort();
    bit seen;
    @(negedge clk);
    we = 1'b0;
    byte_m = 1'b0;
    addr = 20'h00020;
    wr_data = 16'h5A3C;
    stb = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rwe !== 1'b0) begin n_bad++; $display("FAIL t5_strobe: rwe_=%b want 0 before abort", rwe); end
    boot = 1'b1;
    stb = 1'b0;
    #1;
    n_cmp++;
    if (rwe !== 1'b1 || rcs !== 1'b1 || ack !== 1'b0 || !released(d0) || !released(d1)) begin
      n_bad++;
      $display("FAIL t5_abort: rwe_=%b rcs_=%b ack=%b d0=%h d1=%h, want 1 1 0 released",
               rwe, rcs, ack, d0, d1);
    end
    @(negedge clk);
    boot = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL t5_no_ack: got ack=1 want none"); end
    ref_mem[20'h20] = 8'h11;
    ref_mem[20'h21] = 8'h22;
    op(1'b0, 1'b0, 20'h00020, 16'h2211, 1'b0);
    n_cmp++;
    if (got_lat != 4) begin n_bad++; $display("FAIL t5_recover_wr: got %0d want 4", got_lat); end
    op(1'b1, 1'b0, 20'h00020, 16'h0000, 1'b0);
    n_cmp++;
    if (got_lat != 4 || rd_data !== 16'h2211) begin
      n_bad++;
      $display("FAIL t5_recover_rd: lat %0d data %h, want 4 2211", got_lat, rd_data);
    end
  endtask

  task automatic test_random();
    logic w, b;
    logic [19:0] a, a1;
    logic [15:0] wd, exp;
    int exp_lat;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      b = 1'($urandom);
      a = $urandom_range(0, 1) ? 20'($urandom_range(0, 63)) : 20'hFFFC0 + 20'($urandom_range(0, 63));
      a1 = a + 20'd1;
      wd = 16'($urandom);
      exp_lat = (!b && a[1:0] == 2'd3) ? 8 : 4;
      if (w) exp = b ? {8'h00, ref_mem[a]} : {ref_mem[a1], ref_mem[a]};
      else begin
        exp = rd_data;
        ref_mem[a] = wd[7:0];
        if (!b) ref_mem[a1] = wd[15:8];
      end
      op(w, b, a, wd, 1'b0);
      n_cmp++;
      if (got_lat != exp_lat) begin
        n_bad++;
        $display("FAIL rnd_latency: op %0d we=%b byte=%b addr=%h got %0d want %0d", i, w, b, a, got_lat, exp_lat);
      end
      n_cmp++;
      if (rd_data !== exp) begin
        n_bad++;
        $display("FAIL rnd_rd_data: op %0d we=%b byte=%b addr=%h got %h want %h", i, w, b, a, rd_data, exp);
      end
      if (!w) begin
        ok = 1'b1;
        for (int k = -2; k < 4; k++) if (sram_byte(a + 20'(k)) !== ref_mem[a + 20'(k)]) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL rnd_memory: op %0d byte=%b addr=%h data=%h not stored as expected", i, b, a, wd);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0 || rcs !== 1'b1) begin
        n_bad++;
        $display("FAIL rnd_idle: op %0d ack=%b rcs_=%b want 0 1", i, ack, rcs);
      end
    end
  endtask

  task automatic test_stb_held();
    int first, second;
    logic [15:0] exp, rd_first;
    exp = {8'h00, ref_mem[20'h2]};
    first = 0;
    second = 0;
    rd_first = '0;
    @(negedge clk);
    we3 = 1'b1;
    byte3 = 1'b1;
    addr3 = 20'h00002;
    stb3 = 1'b1;
    for (int n = 1; n <= 30 && second == 0; n++) begin
      @(negedge clk);
      if (ack3) begin
        if (first == 0) begin
          first = n;
          rd_first = rd_data3;
        end else second = n;
      end
    end
    stb3 = 1'b0;
    n_cmp++;
    if (first != 6) begin n_bad++; $display("FAIL t6_first_ack: got %0d want 6", first); end
    n_cmp++;
    if (second != 13) begin n_bad++; $display("FAIL t6_second_ack: got %0d want 13", second); end
    n_cmp++;
    if (rd_first !== exp || rd_data3 !== exp) begin
      n_bad++;
      $display("FAIL t6_rd_data: got %h/%h want %h", rd_first, rd_data3, exp);
    end
  endtask

  initial begin
    logic [15:0] w0, w1;
    logic [19:0] base;
    for (int r = 0; r < 262144; r++) begin
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      mem0[r] <= w0;
      mem1[r] <= w1;
      base = {18'(r), 2'b00};
      ref_mem[base] = w0[7:0];
      ref_mem[base + 20'd1] = w0[15:8];
      ref_mem[base + 20'd2] = w1[7:0];
      ref_mem[base + 20'd3] = w1[15:8];
    end
    test_reset();
    test_word_read();
    test_byte_write();
    test_split_read();
    test_wrap_write();
    test_boot_abort();
    test_random();
    test_stb_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
